// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory store buffer: size encodings,
// default widths, the entry layout, and width helpers.
package dm_pkg;

    // Store size encodings carried on st_size (k>0 means 2^(k-1) bytes)
    localparam int unsigned SZ_NONE = 0;
    localparam int unsigned SZ_BYTE = 1;
    localparam int unsigned SZ_HALF = 2;
    localparam int unsigned SZ_WORD = 3;

    localparam int unsigned DM_DATA_W = 32;
    localparam int unsigned DM_ADDR_W = 32;
    localparam int unsigned DM_NB     = DM_DATA_W / 8;

    // Buffer entry: word-aligned address, lane-positioned data, byte enables
    typedef struct packed {
        logic [DM_ADDR_W-1:0] addr;
        logic [DM_DATA_W-1:0] data;
        logic [DM_NB-1:0]     be;
    } dm_entry_t;

    // Width of the st_size field for a word of nb bytes
    function automatic int unsigned sz_w(int unsigned nb);
        return $clog2($clog2(nb) + 2);
    endfunction

endpackage

// File: rtl/dm_store_buffer_if.sv
// Store-request and memory-drain signal bundle for dm_store_buffer.
// slave: the buffer's view; master: the pipeline/memory side.
interface dm_store_buffer_if
    import dm_pkg::*;
#(
    parameter int unsigned DATA_W = DM_DATA_W,
    parameter int unsigned ADDR_W = DM_ADDR_W,
    parameter int unsigned DEPTH  = 4
) ();

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned SZ_W  = sz_w(NB);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              st_valid;
    logic [SZ_W-1:0]   st_size;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_ready;
    logic              st_ades;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [NB-1:0]     mem_be;
    logic              mem_ack;
    logic [CNT_W-1:0]  sb_count;
    logic              sb_empty;

    modport slave (
        input  st_valid, st_size, st_addr, st_data, mem_ack,
        output st_ready, st_ades, mem_req, mem_addr, mem_wdata, mem_be,
               sb_count, sb_empty
    );

    modport master (
        output st_valid, st_size, st_addr, st_data, mem_ack,
        input  st_ready, st_ades, mem_req, mem_addr, mem_wdata, mem_be,
               sb_count, sb_empty
    );

endinterface

// File: rtl/dm_be_gen.sv
// Combinational size check, byte-enable generation and lane shift for a
// store of st_size bytes at byte lane `lane` within a DATA_W-bit word.
module dm_be_gen
    import dm_pkg::*;
#(
    parameter int unsigned DATA_W = DM_DATA_W
) (
    input  logic [sz_w(DATA_W/8)-1:0]    size,
    input  logic [$clog2(DATA_W/8)-1:0]  lane,
    input  logic [DATA_W-1:0]            data,
    output logic                         ok_c,
    output logic [DATA_W/8-1:0]          be_c,
    output logic [DATA_W-1:0]            wdata_c
);

    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned LB = $clog2(NB);

    // Legal size + natural alignment, then enables and data placed at the lane
    always_comb begin
        int unsigned sz;
        int unsigned base;
        int unsigned nbytes;
        logic        size_ok;
        sz      = 32'(size);
        base    = 32'(lane);
        size_ok = (sz != SZ_NONE) && (sz <= LB + 1);
        nbytes  = size_ok ? (32'd1 << (sz - SZ_BYTE)) : 32'd1;
        ok_c    = size_ok && ((base & (nbytes - 32'd1)) == 32'd0);
        be_c    = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            be_c[i] = ok_c && (i >= base) && (i < base + nbytes);
        end
        wdata_c = data << (base * 32'd8);
    end

endmodule

// File: rtl/dm_store_buffer.sv
// FIFO store buffer between the MEM stage and data memory.
// Optional feature macro: DM_SB_MERGE_EN -- merge a store into the tail
// entry when it hits the same word and the tail is not the presented head.
module dm_store_buffer
    import dm_pkg::*;
#(
    parameter int unsigned DATA_W = DM_DATA_W,
    parameter int unsigned ADDR_W = DM_ADDR_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic               clk,
    input  logic               reset,
    dm_store_buffer_if.slave   bus
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned LB    = $clog2(NB);
    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = PW + 1;

    // Same field layout as dm_entry_t, sized by this instance's parameters
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [NB-1:0]     be;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              ades;

    logic              ok;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] word_addr;
    logic              merge;
    logic              not_full;
    logic              ready;
    logic              alloc;
    logic              pop;
    entry_t            new_entry;

    dm_be_gen #(.DATA_W(DATA_W)) u_be_gen (
        .size    (bus.st_size),
        .lane    (bus.st_addr[LB-1:0]),
        .data    (bus.st_data),
        .ok_c    (ok),
        .be_c    (be),
        .wdata_c (wdata)
    );

    assign word_addr = {bus.st_addr[ADDR_W-1:LB], LB'(0)};
    assign new_entry = '{addr: word_addr, data: wdata, be: be};

`ifdef DM_SB_MERGE_EN
    logic [PW-1:0] tail_ptr;
    entry_t        merged;

    assign tail_ptr = wr_ptr - PW'(1);
    assign merge    = bus.st_valid && ok && (count >= CNT_W'(2))
                      && (mem[tail_ptr].addr == word_addr);

    // Tail entry with the new store's lanes overlaid
    always_comb begin
        merged    = mem[tail_ptr];
        merged.be = merged.be | be;
        for (int unsigned i = 0; i < NB; i++) begin
            if (be[i]) merged.data[8*i +: 8] = wdata[8*i +: 8];
        end
    end
`else
    assign merge = 1'b0;
`endif

    assign not_full = count < CNT_W'(DEPTH);
    assign ready    = not_full || merge;
    assign alloc    = bus.st_valid && ready && ok && !merge;
    assign pop      = (count != '0) && bus.mem_ack;

    // Entry storage: allocate at the write pointer, or merge into the tail
    always_ff @(posedge clk) begin
        if (alloc) begin
            mem[wr_ptr] <= new_entry;
        end
`ifdef DM_SB_MERGE_EN
        else if (merge) begin
            mem[tail_ptr] <= merged;
        end
`endif
    end

    // Pointers, occupancy and the address-error pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ades   <= 1'b0;
        end else begin
            if (alloc) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            if (alloc && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !alloc) begin
                count <= count - CNT_W'(1);
            end
            ades <= bus.st_valid && (bus.st_size != '0) && !ok;
        end
    end

    assign bus.st_ready  = ready;
    assign bus.st_ades   = ades;
    assign bus.mem_req   = (count != '0);
    assign bus.mem_addr  = mem[rd_ptr].addr;
    assign bus.mem_wdata = mem[rd_ptr].data;
    assign bus.mem_be    = (count == '0) ? '0 : mem[rd_ptr].be;
    assign bus.sb_count  = count;
    assign bus.sb_empty  = (count == '0);

endmodule

// File: tb/tb_dm_store_buffer.sv
// Bench for dm_store_buffer: directed cases with literal expectations plus
// randomized traffic against a queue-based model of the buffer.
module tb_dm_store_buffer;
    import dm_pkg::*;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    dm_store_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    dm_store_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int        n_cmp = 0;
    int        n_bad = 0;
    dm_entry_t mq[$];
    logic      m_ades = 1'b0;
    bit        live   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model rules: size k means 2^(k-1) bytes, naturally aligned
    function automatic bit m_ok(input logic [1:0] sz, input logic [31:0] a);
        int unsigned nb;
        if (sz == 2'd0) return 1'b0;
        nb = 32'd1 << (sz - 2'd1);
        return (a % nb) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        int unsigned nb;
        nb = 32'd1 << (sz - 2'd1);
        return 4'(((32'd1 << nb) - 32'd1) << (a % 4));
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] b);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (b[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic bit m_merge();
`ifdef DM_SB_MERGE_EN
        return bus.st_valid && m_ok(bus.st_size, bus.st_addr) && (mq.size() >= 2)
               && (mq[mq.size()-1].addr == {bus.st_addr[31:2], 2'b00});
`else
        return 1'b0;
`endif
    endfunction

    // Model state update at each rising edge
    always @(posedge clk) begin
        if (!reset) begin
            mq.delete();
            m_ades = 1'b0;
            live   = 1'b1;
        end else if (live) begin
            bit        ok, mrg, acc, pop;
            dm_entry_t e;
            logic [31:0] msk;
            ok  = m_ok(bus.st_size, bus.st_addr);
            mrg = m_merge();
            acc = bus.st_valid && ok && ((mq.size() < DEPTH) || mrg);
            pop = (mq.size() != 0) && bus.mem_ack;
            m_ades = bus.st_valid && (bus.st_size != 2'd0) && !ok;
            e.addr = {bus.st_addr[31:2], 2'b00};
            e.be   = acc ? m_be(bus.st_size, bus.st_addr) : 4'd0;
            e.data = bus.st_data << (8 * (bus.st_addr % 4));
            if (pop) void'(mq.pop_front());
            if (acc && mrg) begin
                msk = lane_mask(e.be);
                mq[mq.size()-1].data = (mq[mq.size()-1].data & ~msk) | (e.data & msk);
                mq[mq.size()-1].be   = mq[mq.size()-1].be | e.be;
            end else if (acc) begin
                mq.push_back(e);
            end
        end
    end

    // Compare DUT outputs with the model every cycle, mid-period
    always @(negedge clk) begin
        if (live) begin
            chk("st_ready", bus.st_ready, (mq.size() < DEPTH) || m_merge());
            chk("sb_count", bus.sb_count, mq.size());
            chk("sb_empty", bus.sb_empty, mq.size() == 0);
            chk("mem_req", bus.mem_req, mq.size() != 0);
            chk("st_ades", bus.st_ades, m_ades);
            if (mq.size() != 0) begin
                chk("mem_addr", bus.mem_addr, mq[0].addr);
                chk("mem_be", bus.mem_be, mq[0].be);
                chk("mem_wdata", bus.mem_wdata & lane_mask(mq[0].be),
                    mq[0].data & lane_mask(mq[0].be));
            end else begin
                chk("mem_be_empty", bus.mem_be, 0);
            end
        end
    end

    task automatic drive(input bit v, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d, input bit ack);
        bus.st_valid = v;
        bus.st_size  = sz;
        bus.st_addr  = a;
        bus.st_data  = d;
        bus.mem_ack  = ack;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_sb_count", bus.sb_count, 0);
        chk("rst_st_ready", bus.st_ready, 1);
        chk("rst_st_ades", bus.st_ades, 0);
        chk("rst_mem_be", bus.mem_be, 0);

        // Byte store at lane 3 appears the next cycle
        drive(1'b1, 2'(SZ_BYTE), 32'h1003, 32'h0000_00AB, 1'b0);
        step();
        idle();
        chk("sb_mem_req", bus.mem_req, 1);
        chk("sb_mem_addr", bus.mem_addr, 32'h1000);
        chk("sb_mem_be", bus.mem_be, 4'b1000);
        chk("sb_lane3", bus.mem_wdata[31:24], 8'hAB);
        drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b1);
        step();
        idle();
        chk("drain_count", bus.sb_count, 0);

        // Misaligned halfword: no enqueue, one-cycle address error
        drive(1'b1, 2'(SZ_HALF), 32'h2001, 32'h1234, 1'b0);
        step();
        idle();
        chk("ades_pulse", bus.st_ades, 1);
        chk("ades_count", bus.sb_count, 0);
        step();
        chk("ades_clear", bus.st_ades, 0);

        // Fill to full, stall a fifth store, then free one slot
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(SZ_WORD), 32'h200 + 32'(4 * i), $urandom, 1'b0);
            step();
        end
        idle();
        chk("full_count", bus.sb_count, 4);
        chk("full_ready", bus.st_ready, 0);
        drive(1'b1, 2'(SZ_WORD), 32'h300, 32'h5555_5555, 1'b0);
        #1;
        chk("stall_ready", bus.st_ready, 0);
        step();
        idle();
        chk("stall_count", bus.sb_count, 4);
        drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b1);
        step();
        idle();
        chk("ack_count", bus.sb_count, 3);
        chk("ack_ready", bus.st_ready, 1);
        chk("ack_head", bus.mem_addr, 32'h204);
        chk("pre_rst_req", bus.mem_req, 1);

        // Reset mid-drain with an ack present discards everything
        drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        idle();
        chk("mid_rst_req", bus.mem_req, 0);
        chk("mid_rst_count", bus.sb_count, 0);
        chk("mid_rst_ready", bus.st_ready, 1);

        // Push+pop at occupancy 2 across pointer wrap
        drive(1'b1, 2'(SZ_WORD), 32'h100, 32'h1, 1'b0);
        step();
        drive(1'b1, 2'(SZ_WORD), 32'h104, 32'h2, 1'b0);
        step();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'(SZ_WORD), 32'h108 + 32'(4 * k), 32'(k + 3), 1'b1);
            step();
            chk("wrap_count", bus.sb_count, 2);
            chk("wrap_head", bus.mem_addr, 32'h104 + 32'(4 * k));
        end
        drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b1);
        step();
        step();
        idle();
        chk("wrap_drained", bus.sb_count, 0);

        // Two byte stores to the word behind a word store
        drive(1'b1, 2'(SZ_WORD), 32'h10, 32'hDEAD_BEEF, 1'b0);
        step();
        drive(1'b1, 2'(SZ_BYTE), 32'h20, 32'h11, 1'b0);
        step();
        drive(1'b1, 2'(SZ_BYTE), 32'h21, 32'h22, 1'b0);
        step();
        idle();
`ifdef DM_SB_MERGE_EN
        chk("merge_count", bus.sb_count, 2);
`else
        chk("merge_count", bus.sb_count, 3);
`endif
        drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b1);
        step();
        idle();
        chk("merge_head_addr", bus.mem_addr, 32'h20);
`ifdef DM_SB_MERGE_EN
        chk("merge_be", bus.mem_be, 4'b0011);
        chk("merge_wdata", bus.mem_wdata[15:0], 16'h2211);
`else
        chk("merge_be", bus.mem_be, 4'b0001);
        chk("merge_wdata", bus.mem_wdata[7:0], 8'h11);
`endif
        reset = 1'b0;
        step();
        reset = 1'b1;

        // Randomized traffic with word-address reuse and occasional reset
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            case ($urandom_range(0, 3))
                0:       a = 32'h40;
                1:       a = 32'h44;
                2:       a = 32'h48;
                default: a = 32'h80;
            endcase
            a[1:0] = 2'($urandom_range(0, 3));
            drive($urandom_range(0, 99) < 70, 2'($urandom_range(0, 3)), a, $urandom,
                  $urandom_range(0, 99) < 40);
            reset = ($urandom_range(0, 149) != 0);
            step();
        end
        idle();
        reset = 1'b1;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
